// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, clock mode constants, helpers.
package spi_pkg;

  // Mode 0: SCLK idles low, data sampled on the rising edge.
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_HOLD  = 3'd4
  } spi_state_e;

  // Counter width that still works for a modulus of 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Front-end handshake between a register/bus block and the SPI master.
interface spi_master_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  busy;
  logic                  done;

  // Requester side (register front end or bench).
  modport master (output start, tx_data, input rx_data, busy, done);
  // SPI master side.
  modport slave (input start, tx_data, output rx_data, busy, done);

endinterface

// File: rtl/spi_sclk_tick.sv
// Half-period divider: counts down from CLK_DIV-1 and ticks on terminal count.
module spi_sclk_tick
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick_c
);

  localparam int unsigned           CNT_W  = cnt_width(CLK_DIV);
  localparam logic [CNT_W-1:0]      RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Reload on clear or terminal count, otherwise count down.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear || (cnt_q == '0)) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Clear masks the tick so a phase always lasts a full CLK_DIV cycles.
  assign tick_c = !clear && (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// Single-frame SPI master, mode 0, MSB first, full duplex.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  spi_master_if.slave      bus,
  output logic             SCLK,
  output logic             MOSI,
  input  logic             MISO,
  output logic             CS
);

  localparam int unsigned      BC_W     = $clog2(DATA_WIDTH + 1);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_WIDTH - 1);
  localparam logic [BC_W-1:0]  HOLD_MID = BC_W'(DATA_WIDTH);

  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_q, cs_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tick_c;

  // Divider is held in reload while idle so SETUP starts a fresh half-period.
  spi_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q == ST_IDLE),
    .tick_c  (tick_c)
  );

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= CPOL;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and next-output logic; every phase advances on a divider tick.
  always_comb begin
    state_d   = state_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          tx_sh_d   = bus.tx_data;
          mosi_d    = bus.tx_data[DATA_WIDTH-1];
          cs_d      = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_SETUP;
        end
      end

      ST_SETUP, ST_LOW: begin
        if (tick_c) begin
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], MISO};
          state_d = ST_HIGH;
        end
      end

      ST_HIGH: begin
        if (tick_c) begin
          sclk_d = 1'b0;
          if (bit_cnt_q < LAST_BIT) begin
            tx_sh_d   = tx_sh_q << 1;
            mosi_d    = tx_sh_q[DATA_WIDTH-2];
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = ST_LOW;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end

      // Two half-periods: trailing SCLK-low time, then CS hold before release.
      ST_HOLD: begin
        if (tick_c) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = HOLD_MID;
          end else begin
            cs_d      = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            rx_data_d = rx_sh_q;
            mosi_d    = 1'b0;
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign SCLK        = sclk_q;
  assign CS          = cs_q;
  assign MOSI        = mosi_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: CLK_DIV=2 main instance, CLK_DIV=1 variant.
module tb_spi_master;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_if #(.DATA_WIDTH(DW)) bus1 ();
  spi_master_if #(.DATA_WIDTH(DW)) bus2 ();

  logic sclk1, mosi1, cs1;
  wire  miso1;
  logic sclk2, mosi2, cs2;

  logic          loop1;
  logic [DW-1:0] slave_byte;
  logic [DW-1:0] slv_sh;

  spi_master #(.DATA_WIDTH(DW), .CLK_DIV(2)) u1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1),
    .SCLK    (sclk1),
    .MOSI    (mosi1),
    .MISO    (miso1),
    .CS      (cs1)
  );

  spi_master #(.DATA_WIDTH(DW), .CLK_DIV(1)) u2 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus2),
    .SCLK    (sclk2),
    .MOSI    (mosi2),
    .MISO    (mosi2),
    .CS      (cs2)
  );

  // Mode-0 slave model: first bit presented when CS falls, next on each SCLK fall.
  always @(negedge cs1) slv_sh = slave_byte;
  always @(negedge sclk1) if (!cs1) slv_sh = {slv_sh[DW-2:0], 1'b0};
  assign miso1 = loop1 ? mosi1 : (cs1 ? 1'bz : slv_sh[DW-1]);

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int            lat, rises, dones;
  logic [DW-1:0] mbits;
  logic          e0_busy, e0_cs, e0_mosi, prev_sclk;

  // Start one frame on u1 and watch it for 'budget' cycles after the accepting edge.
  task automatic frame1(input logic [DW-1:0] data, input int budget, input int restart_at);
    bus1.tx_data = data;
    bus1.start   = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    e0_busy   = bus1.busy;
    e0_cs     = cs1;
    e0_mosi   = mosi1;
    lat       = 0;
    rises     = 0;
    dones     = 0;
    mbits     = '0;
    prev_sclk = sclk1;
    for (int k = 1; k <= budget; k++) begin
      if (k == restart_at) begin
        bus1.tx_data = 8'hFF;
        bus1.start   = 1'b1;
      end else if (k == restart_at + 1) begin
        bus1.start = 1'b0;
      end
      @(posedge clk); #1;
      if (sclk1 && !prev_sclk) begin
        rises++;
        mbits = {mbits[DW-2:0], mosi1};
      end
      prev_sclk = sclk1;
      if (bus1.done) begin
        dones++;
        if (lat == 0) lat = k;
      end
    end
  endtask

  int            d1, d2, r1, r2, rises2, rises_first, cs_high;
  logic [DW-1:0] rx_first;
  logic          prev2;

  initial begin
    bus1.start = 1'b0; bus1.tx_data = '0;
    bus2.start = 1'b0; bus2.tx_data = '0;
    loop1 = 1'b0; slave_byte = '0; slv_sh = '0;

    // Reset values
    repeat (3) @(posedge clk); #1;
    check("rst_cs",   cs1,          1);
    check("rst_sclk", sclk1,        0);
    check("rst_mosi", mosi1,        0);
    check("rst_busy", bus1.busy,    0);
    check("rst_done", bus1.done,    0);
    check("rst_rx",   bus1.rx_data, 8'h00);
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // A5 out, slave returns 3C
    slave_byte = 8'h3C;
    frame1(8'hA5, 44, 0);
    check("a5_e0_busy", e0_busy, 1);
    check("a5_e0_cs",   e0_cs,   0);
    check("a5_e0_mosi", e0_mosi, 1);
    check("a5_latency", lat,     36);
    check("a5_rises",   rises,   8);
    check("a5_mosi",    mbits,   8'hA5);
    check("a5_dones",   dones,   1);
    check("a5_rx",      bus1.rx_data, 8'h3C);
    check("a5_cs_end",  cs1,     1);
    check("a5_busy_end", bus1.busy, 0);

    // Loopback 5A
    loop1 = 1'b1;
    frame1(8'h5A, 44, 0);
    check("5a_latency", lat,   36);
    check("5a_mosi",    mbits, 8'h5A);
    check("5a_rx",      bus1.rx_data, 8'h5A);

    // Second start 5 cycles into the frame is ignored
    frame1(8'hC3, 44, 5);
    check("busy_start_latency", lat,   36);
    check("busy_start_mosi",    mbits, 8'hC3);
    check("busy_start_dones",   dones, 1);
    check("busy_start_rx",      bus1.rx_data, 8'hC3);
    check("busy_start_idle",    bus1.busy, 0);

    // Reset after the 3rd SCLK rise aborts the frame without a clock edge
    bus1.tx_data = 8'h0F;
    bus1.start   = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    rises = 0;
    prev_sclk = sclk1;
    for (int k = 0; k < 40 && rises < 3; k++) begin
      @(posedge clk); #1;
      if (sclk1 && !prev_sclk) rises++;
      prev_sclk = sclk1;
    end
    check("abort_reach_rise3", rises, 3);
    #2 reset_n = 1'b0;
    #1;
    check("abort_cs",   cs1,          1);
    check("abort_sclk", sclk1,        0);
    check("abort_mosi", mosi1,        0);
    check("abort_busy", bus1.busy,    0);
    check("abort_rx",   bus1.rx_data, 8'h00);
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus1.done) dones++;
    end
    check("abort_no_done", dones, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    frame1(8'h81, 44, 0);
    check("post_abort_latency", lat,   36);
    check("post_abort_mosi",    mbits, 8'h81);
    check("post_abort_dones",   dones, 1);
    check("post_abort_rx",      bus1.rx_data, 8'h81);

    // CLK_DIV=1: start held through done, back-to-back frames
    bus2.tx_data = 8'h96;
    bus2.start   = 1'b1;
    @(posedge clk); #1;
    d1 = 0; d2 = 0; r1 = 0; r2 = 0; rises2 = 0; rises_first = 0; cs_high = 0;
    rx_first = '0;
    prev2 = sclk2;
    for (int k = 1; k <= 44; k++) begin
      @(posedge clk); #1;
      if (sclk2 && !prev2) begin
        rises2++;
        if (r1 == 0) r1 = k;
        else if (r2 == 0) r2 = k;
      end
      prev2 = sclk2;
      if (bus2.done) begin
        if (d1 == 0) begin
          d1 = k;
          rx_first = bus2.rx_data;
          rises_first = rises2;
        end else if (d2 == 0) begin
          d2 = k;
        end
      end
      if (d1 != 0 && k <= d1 + 3 && cs2) cs_high++;
      if (d1 != 0 && k == d1) bus2.tx_data = 8'h69;
      if (d1 != 0 && k == d1 + 1) bus2.start = 1'b0;
    end
    check("div1_first_done",  d1,          18);
    check("div1_rise1",       r1,          1);
    check("div1_rise2",       r2,          3);
    check("div1_rises",       rises_first, 8);
    check("div1_rx_first",    rx_first,    8'h96);
    check("div1_cs_high",     cs_high,     1);
    check("div1_second_done", d2,          37);
    check("div1_rx_second",   bus2.rx_data, 8'h69);
    check("div1_idle_end",    bus2.busy,   0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
